crop_pad: RTL and testbench
===========================

Name: crop_pad

Overview:
- Inverse of the crop stage: consumes an OUT_ROWS x OUT_COLS cropped pixel stream.
- Re-embeds it into a full IN_ROWS x IN_COLS raster at (crop_x0, crop_y0); every position outside the window carries FILL_VALUE.
- Sits downstream of the inference/crop path and feeds full-frame consumers (display/DMA) with a position-correct frame.
- Driven by the same ap_start/ap_done/ap_ready control convention as the other stream blocks.

Parameters:
- PIXEL_BIT_WIDTH, 10, pixel data width.
- IN_ROWS, 20, full-frame rows.
- IN_COLS, 20, full-frame columns.
- OUT_ROWS, 10, cropped window rows; must be <= IN_ROWS.
- OUT_COLS, 10, cropped window columns; must be <= IN_COLS.
- FILL_VALUE, 0, pixel value emitted outside the window (PIXEL_BIT_WIDTH bits).

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- ap_start  in  1  start-of-frame request; sampled only in IDLE.
- ap_ready  out  1  high in IDLE (can accept ap_start).
- ap_done  out  1  one-cycle pulse when the last frame pixel is accepted downstream.
- crop_x0  in  $clog2(IN_COLS)  window left column; latched on ap_start.
- crop_y0  in  $clog2(IN_ROWS)  window top row; latched on ap_start.
- s_axis_tvalid  in  1  cropped pixel valid.
- s_axis_tready  out  1  cropped pixel accepted.
- s_axis_tdata  in  PIXEL_BIT_WIDTH  cropped pixel.
- m_axis_tvalid  out  1  full-frame pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  PIXEL_BIT_WIDTH  full-frame pixel, raster order.
- cnt_col  out  $clog2(IN_COLS)  column of the pixel being produced.
- cnt_row  out  $clog2(IN_ROWS)  row of the pixel being produced.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, ap_done=0, ap_ready=1, counters=0, state=IDLE.
- FSM states are IDLE and RUN.
- IDLE -> RUN on ap_start. On that transition:
  - Latch x0 = min(crop_x0, IN_COLS-OUT_COLS) and y0 = min(crop_y0, IN_ROWS-OUT_ROWS).
  - Clear cnt_row and cnt_col.
- In RUN, ap_start is ignored.
- Window test: (cnt_row >= y0) && (cnt_row < y0+OUT_ROWS) && (cnt_col >= x0) && (cnt_col < x0+OUT_COLS). Sums are evaluated one bit wider than the counters, so there is no wrap.
- The output is a one-stage register slice, 1-cycle latency. Load enable: (!m_axis_tvalid || m_axis_tready).
  - Inside the window: s_axis_tready = load_en. On s_axis_tvalid && s_axis_tready, load s_axis_tdata and advance the position. With no input valid, no load and the position holds (bubble).
  - Outside the window: s_axis_tready = 0. Load FILL_VALUE on every load_en and advance the position.
- m_axis_tdata/m_axis_tvalid stay stable while m_axis_tvalid && !m_axis_tready (AXI rule).
- Position advance: cnt_col increments; at IN_COLS-1 it wraps to 0 and cnt_row increments.
- The final position (IN_ROWS-1, IN_COLS-1), once loaded, sets a last flag; no further loads occur.
- When the last-flagged beat is accepted downstream:
  - ap_done pulses for exactly 1 cycle.
  - State returns to IDLE and ap_ready rises the same cycle.
- Back-to-back frames: ap_start asserted during the ap_done cycle is not honoured; it is honoured from the next cycle in IDLE.
- Input beats presented while in IDLE are not accepted (s_axis_tready=0).
- srst at any point, including mid-frame, returns all state to reset values. The partial frame is discarded; no ap_done.
- Exact pixel accounting: each frame consumes exactly OUT_ROWS*OUT_COLS input beats and emits exactly IN_ROWS*IN_COLS output beats.

Optional Feature:
- Macro: CROP_PAD_TLAST_EN.
- When defined, two extra output ports are added and carried in the output register slice:
  - m_axis_tlast: high on the last column of every row.
  - m_axis_tuser: high on pixel (0,0) of each frame.
- When undefined, the ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package crop_pkg holds:
  - the FSM enum typedef (IDLE, RUN);
  - a typedef for a window-origin struct {x0, y0};
  - a localparam helper for counter widths.
- One sub-module: axis_reg_slice, a single-entry output register parameterised by data width. It carries tdata plus the optional tlast/tuser bits.

Test Plan:
- Frame fill, IN=6x6, OUT=3x3, FILL=0, x0=2, y0=1, input 1..9, m_axis_tready=1 -> 36 beats out; rows 1-3 cols 2-4 carry 1..9 in raster order, all others 0; ap_done pulses once, after the 36th beat.
- Backpressure: same setup with m_axis_tready toggling 50% random and s_axis_tvalid gaps -> identical 36-beat sequence; tdata never changes while valid && !ready.
- Clamp: x0=5, y0=5 on a 6x6/3x3 frame -> window placed at (3,3); exactly 9 inputs consumed.
- Full-size window: OUT=IN=6x6 -> output equals input beat-for-beat; s_axis_tready never deasserts when m_axis_tready=1.
- srst after 10 output beats -> m_axis_tvalid=0 and ap_ready=1 next cycle, no ap_done; a following ap_start produces a full correct frame.
- With CROP_PAD_TLAST_EN: tlast on beats 6,12,...,36 and tuser on beat 1 only.

Source files
------------

// File: rtl/crop_pad_pkg.sv
// Shared types and helpers for the crop_pad re-embedding stage.
// Optional tlast/tuser sideband is enabled by defining CROP_PAD_TLAST_EN.
package crop_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Origin fields are kept wide so window-end sums never wrap.
  localparam int ORIGIN_W = 16;

  typedef struct packed {
    logic [ORIGIN_W-1:0] x0;
    logic [ORIGIN_W-1:0] y0;
  } origin_t;

  function automatic int cntW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crop_pad_if.sv
// AXI-Stream style pixel bus used on both sides of crop_pad.
// Defining CROP_PAD_TLAST_EN adds tlast/tuser to the master side.
interface crop_pad_if #(
  parameter int DATA_W = 10
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
`ifdef CROP_PAD_TLAST_EN
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
`else
  modport master (output tvalid, output tdata, input tready);
`endif
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/crop_pad_reg_slice.sv
// Single-entry output register slice (axis_reg_slice) holding the next pixel.
// Carries tlast/tuser as well when CROP_PAD_TLAST_EN is defined.
module axis_reg_slice #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
`ifdef CROP_PAD_TLAST_EN
  input  logic              i_last,
  input  logic              i_user,
  output logic              o_last,
  output logic              o_user,
`endif
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
`ifdef CROP_PAD_TLAST_EN
  logic              r_last;
  logic              r_user;
`endif

  // A load always wins; otherwise a downstream accept empties the slot.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef CROP_PAD_TLAST_EN
      r_last  <= 1'b0;
      r_user  <= 1'b0;
`endif
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
`ifdef CROP_PAD_TLAST_EN
      r_last  <= i_last;
      r_user  <= i_user;
`endif
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
`ifdef CROP_PAD_TLAST_EN
  assign o_last  = r_last;
  assign o_user  = r_user;
`endif

endmodule

// File: rtl/crop_pad.sv
// Re-embeds a cropped OUT_ROWS x OUT_COLS stream into a full IN_ROWS x IN_COLS frame.
// Define CROP_PAD_TLAST_EN to emit m_axis.tlast (row end) and m_axis.tuser (frame start).
module crop_pad
  import crop_pkg::*;
#(
  parameter int                         PIXEL_BIT_WIDTH = 10,
  parameter int                         IN_ROWS         = 20,
  parameter int                         IN_COLS         = 20,
  parameter int                         OUT_ROWS        = 10,
  parameter int                         OUT_COLS        = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] FILL_VALUE      = '0
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_done,
  input  logic [cntW(IN_COLS)-1:0]   crop_x0,
  input  logic [cntW(IN_ROWS)-1:0]   crop_y0,
  crop_pad_if.slave                  s_axis,
  crop_pad_if.master                 m_axis,
  output logic [cntW(IN_COLS)-1:0]   cnt_col,
  output logic [cntW(IN_ROWS)-1:0]   cnt_row
);

  localparam int                  CW     = cntW(IN_COLS);
  localparam int                  RW     = cntW(IN_ROWS);
  localparam logic [ORIGIN_W-1:0] MAX_X0 = ORIGIN_W'(IN_COLS - OUT_COLS);
  localparam logic [ORIGIN_W-1:0] MAX_Y0 = ORIGIN_W'(IN_ROWS - OUT_ROWS);

  state_t                     r_state;
  state_t                     w_nextState;
  origin_t                    r_origin;
  logic [CW-1:0]              r_col;
  logic [RW-1:0]              r_row;
  logic                       r_lastLoaded;
  logic                       r_done;
  logic                       w_start;
  logic                       w_finish;
  logic                       w_load;
  logic                       w_sReady;
  logic                       w_loadEn;
  logic                       w_inWin;
  logic                       w_lastCol;
  logic                       w_lastPos;
  logic                       w_outValid;
  logic [PIXEL_BIT_WIDTH-1:0] w_loadData;
  logic [ORIGIN_W-1:0]        w_row16;
  logic [ORIGIN_W-1:0]        w_col16;
  logic [ORIGIN_W-1:0]        w_x0Clamp;
  logic [ORIGIN_W-1:0]        w_y0Clamp;
`ifdef CROP_PAD_TLAST_EN
  logic                       w_tlast;
  logic                       w_tuser;
`endif

  assign w_row16   = ORIGIN_W'(r_row);
  assign w_col16   = ORIGIN_W'(r_col);
  assign w_x0Clamp = (ORIGIN_W'(crop_x0) > MAX_X0) ? MAX_X0 : ORIGIN_W'(crop_x0);
  assign w_y0Clamp = (ORIGIN_W'(crop_y0) > MAX_Y0) ? MAX_Y0 : ORIGIN_W'(crop_y0);
  assign w_inWin   = (w_row16 >= r_origin.y0) && (w_row16 < r_origin.y0 + ORIGIN_W'(OUT_ROWS)) &&
                     (w_col16 >= r_origin.x0) && (w_col16 < r_origin.x0 + ORIGIN_W'(OUT_COLS));
  assign w_loadEn  = !w_outValid || m_axis.tready;
  assign w_lastCol = (r_col == CW'(IN_COLS - 1));
  assign w_lastPos = w_lastCol && (r_row == RW'(IN_ROWS - 1));

  always_ff @(posedge clk) begin
    if (srst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Once the final position is in the slice, only its downstream accept matters.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_sReady    = 1'b0;
    w_load      = 1'b0;
    w_loadData  = FILL_VALUE;
    case (r_state)
      IDLE: begin
        if (ap_start && !r_done) begin
          w_nextState = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (r_lastLoaded) begin
          if (w_outValid && m_axis.tready) begin
            w_nextState = IDLE;
            w_finish    = 1'b1;
          end
        end else if (w_inWin) begin
          w_sReady   = w_loadEn;
          w_load     = s_axis.tvalid && w_loadEn;
          w_loadData = s_axis.tdata;
        end else begin
          w_load = w_loadEn;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Raster position advances with every loaded beat and freezes on the final one.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_origin     <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_lastLoaded <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_origin.x0  <= w_x0Clamp;
        r_origin.y0  <= w_y0Clamp;
        r_col        <= '0;
        r_row        <= '0;
        r_lastLoaded <= 1'b0;
      end else if (w_load) begin
        if (w_lastPos) begin
          r_lastLoaded <= 1'b1;
        end else if (w_lastCol) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

`ifdef CROP_PAD_TLAST_EN
  assign w_tlast = w_lastCol;
  assign w_tuser = (r_row == '0) && (r_col == '0);
`endif

  axis_reg_slice #(.DATA_W(PIXEL_BIT_WIDTH)) u_slice (
    .clk     (clk),
    .srst    (srst),
    .i_load  (w_load),
    .i_data  (w_loadData),
`ifdef CROP_PAD_TLAST_EN
    .i_last  (w_tlast),
    .i_user  (w_tuser),
    .o_last  (m_axis.tlast),
    .o_user  (m_axis.tuser),
`endif
    .i_ready (m_axis.tready),
    .o_valid (w_outValid),
    .o_data  (m_axis.tdata)
  );

  assign m_axis.tvalid = w_outValid;
  assign s_axis.tready = w_sReady;
  assign ap_ready      = (r_state == IDLE);
  assign ap_done       = r_done;
  assign cnt_col       = r_col;
  assign cnt_row       = r_row;

endmodule

// File: tb/tb_crop_pad.sv
// Directed bench for crop_pad: 6x6 frame with a 3x3 window, plus a 6x6 full-size window.
// Sideband checks are compiled in when CROP_PAD_TLAST_EN is defined.
module tb_crop_pad;
  import crop_pkg::*;

  localparam int PW = 10;
  localparam int N  = 6;
  localparam int W  = 3;
  localparam int CW = cntW(N);

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  logic          startA = 1'b0, readyA, doneA;
  logic [CW-1:0] x0A = '0, y0A = '0, colA, rowA;
  logic          startB = 1'b0, readyB, doneB;
  logic [CW-1:0] x0B = '0, y0B = '0, colB, rowB;

  crop_pad_if #(.DATA_W(PW)) sA ();
  crop_pad_if #(.DATA_W(PW)) mA ();
  crop_pad_if #(.DATA_W(PW)) sB ();
  crop_pad_if #(.DATA_W(PW)) mB ();

`ifdef CROP_PAD_TLAST_EN
  assign sA.tlast = 1'b0;
  assign sA.tuser = 1'b0;
  assign sB.tlast = 1'b0;
  assign sB.tuser = 1'b0;
`endif

  crop_pad #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(N), .IN_COLS(N), .OUT_ROWS(W), .OUT_COLS(W), .FILL_VALUE('0)
  ) dutA (
    .clk(clk), .srst(srst), .ap_start(startA), .ap_ready(readyA), .ap_done(doneA),
    .crop_x0(x0A), .crop_y0(y0A), .s_axis(sA), .m_axis(mA), .cnt_col(colA), .cnt_row(rowA)
  );

  crop_pad #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(N), .IN_COLS(N), .OUT_ROWS(N), .OUT_COLS(N), .FILL_VALUE('0)
  ) dutB (
    .clk(clk), .srst(srst), .ap_start(startB), .ap_ready(readyB), .ap_done(doneB),
    .crop_x0(x0B), .crop_y0(y0B), .s_axis(sB), .m_axis(mB), .cnt_col(colB), .cnt_row(rowB)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame on dutA; the window is expected at (ex,ey) carrying 1..W*W.
  task automatic applyStimulus(input int x0, input int y0, input int ex, input int ey,
                               input bit bp, input bit doStart, input int abortAfter);
    int  sendIdx   = 1;
    int  beats     = 0;
    int  dones     = 0;
    int  doneBeat  = -1;
    int  cycles    = 0;
    int  heldData  = 0;
    int  r, c, expPix;
    bit  stall     = 1'b0;
    bit  accepted  = 1'b0;
    if (doStart) begin
      @(negedge clk);
      x0A    = CW'(x0);
      y0A    = CW'(y0);
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
    end
    while (dones == 0 && cycles < 400 && !(abortAfter > 0 && beats >= abortAfter)) begin
      @(negedge clk);
      cycles++;
      if (accepted) begin
        sA.tvalid = 1'b0;
        accepted  = 1'b0;
      end
      mA.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!sA.tvalid && sendIdx <= W*W + 1 && !(bp && $urandom_range(0, 2) == 0)) begin
        sA.tvalid = 1'b1;
        sA.tdata  = PW'(sendIdx);
      end
      #1;
      if (doneA) begin
        dones++;
        doneBeat = beats;
      end
      if (stall) begin
        checkOutput("stallValid", int'(mA.tvalid), 1);
        checkOutput("stallData", int'(mA.tdata), heldData);
      end
      stall    = mA.tvalid && !mA.tready;
      heldData = int'(mA.tdata);
      if (mA.tvalid && mA.tready) begin
        r      = beats / N;
        c      = beats % N;
        expPix = (r >= ey && r < ey + W && c >= ex && c < ex + W) ? 1 + (r - ey) * W + (c - ex) : 0;
        checkOutput($sformatf("pix%0d", beats), int'(mA.tdata), expPix);
`ifdef CROP_PAD_TLAST_EN
        checkOutput($sformatf("tlast%0d", beats), int'(mA.tlast), int'((beats % N) == N - 1));
        checkOutput($sformatf("tuser%0d", beats), int'(mA.tuser), int'(beats == 0));
`endif
        beats++;
      end
      if (sA.tvalid && sA.tready) begin
        sendIdx++;
        accepted = 1'b1;
      end
    end
    sA.tvalid = 1'b0;
    if (abortAfter == 0) begin
      checkOutput("frameDone", dones, 1);
      checkOutput("doneAfterBeat", doneBeat, N*N);
      checkOutput("beatsOut", beats, N*N);
      checkOutput("beatsIn", sendIdx - 1, W*W);
    end
  endtask

  initial begin
    int sendB, beatsB, gapsB, cyc;
    bit accB, seenB;
    sA.tvalid = 1'b0; sA.tdata = '0; mA.tready = 1'b0;
    sB.tvalid = 1'b0; sB.tdata = '0; mB.tready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstReady", int'(readyA), 1);
    checkOutput("rstDone", int'(doneA), 0);
    checkOutput("rstMValid", int'(mA.tvalid), 0);
    checkOutput("rstMData", int'(mA.tdata), 0);
    checkOutput("rstSReady", int'(sA.tready), 0);
    checkOutput("rstCnt", int'(colA) + int'(rowA), 0);
    srst = 1'b0;

    $display("[TB] frame fill x0=2 y0=1");
    applyStimulus(2, 1, 2, 1, 1'b0, 1'b1, 0);

    // Start raised in the ap_done cycle must wait one more cycle.
    checkOutput("readyAtDone", int'(readyA), 1);
    x0A    = CW'(5);
    y0A    = CW'(5);
    startA = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("b2bIgnored", int'(readyA), 1);
    checkOutput("donePulse", int'(doneA), 0);
    @(negedge clk);
    startA = 1'b0;
    #1;
    checkOutput("b2bTaken", int'(readyA), 0);
    $display("[TB] clamp x0=5 y0=5");
    applyStimulus(5, 5, 3, 3, 1'b0, 1'b0, 0);

    $display("[TB] backpressure");
    applyStimulus(2, 1, 2, 1, 1'b1, 1'b1, 0);

    $display("[TB] mid-frame reset");
    applyStimulus(2, 1, 2, 1, 1'b0, 1'b1, 10);
    srst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("abortMValid", int'(mA.tvalid), 0);
    checkOutput("abortReady", int'(readyA), 1);
    checkOutput("abortDone", int'(doneA), 0);
    srst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("abortNoDone", int'(doneA), 0);
    end
    applyStimulus(2, 1, 2, 1, 1'b0, 1'b1, 0);

    $display("[TB] full-size window");
    @(negedge clk);
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    sendB = 1; beatsB = 0; gapsB = 0; cyc = 0; accB = 1'b0; seenB = 1'b0;
    while (!seenB && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (accB) begin
        sB.tvalid = 1'b0;
        accB      = 1'b0;
      end
      mB.tready = 1'b1;
      if (!sB.tvalid && sendB <= N*N) begin
        sB.tvalid = 1'b1;
        sB.tdata  = PW'(sendB);
      end
      #1;
      if (doneB) seenB = 1'b1;
      if (sendB <= N*N && !sB.tready) gapsB++;
      if (mB.tvalid && mB.tready) begin
        checkOutput($sformatf("fullPix%0d", beatsB), int'(mB.tdata), beatsB + 1);
        beatsB++;
      end
      if (sB.tvalid && sB.tready) begin
        sendB++;
        accB = 1'b1;
      end
    end
    sB.tvalid = 1'b0;
    checkOutput("fullDone", int'(seenB), 1);
    checkOutput("fullReadyGaps", gapsB, 0);
    checkOutput("fullBeatsOut", beatsB, N*N);
    checkOutput("fullBeatsIn", sendB - 1, N*N);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
